// File: rtl/alu_word_sequencer_if.sv
// Command/result bundle between the register-file/command logic and the
// multi-word add/subtract sequencer.
interface alu_word_sequencer_if #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 4
);
  localparam int W = WORD_WIDTH * NUM_WORDS;

  logic         start;
  logic         subtract;
  logic         carryInEnable;
  logic         carryIn;
  logic [W-1:0] operandA;
  logic [W-1:0] operandB;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         carryOut;
  logic         overflowOut;
  logic         zeroOut;

  modport master (
    output start, subtract, carryInEnable, carryIn, operandA, operandB,
    input  ready, done, result, carryOut, overflowOut, zeroOut
  );

  modport slave (
    input  start, subtract, carryInEnable, carryIn, operandA, operandB,
    output ready, done, result, carryOut, overflowOut, zeroOut
  );
endinterface

// File: rtl/alu_word_sequencer.sv
// Multi-word add/subtract built on one WORD_WIDTH-bit carry-in/carry-out ALU,
// processing one word per cycle, least-significant word first.
module alu_word_sequencer #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_word_sequencer_if.slave    bus
);
  localparam int W     = WORD_WIDTH * NUM_WORDS;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [W-1:0]          r_a;
  logic [W-1:0]          r_b;
  logic [W-1:0]          r_res_sh;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_carry;
  logic                  r_mode;
  logic                  r_zero_acc;
  logic [W-1:0]          r_result;
  logic                  r_carry_out;
  logic                  r_ovf;
  logic                  r_zero;

  logic                  w_ready;
  logic                  w_done;
  logic                  w_last;
  logic                  w_add_mode;
  logic [WORD_WIDTH-1:0] w_op_a;
  logic [WORD_WIDTH-1:0] w_op_b;
  logic [WORD_WIDTH:0]   w_sum_ext;
  logic [WORD_WIDTH-1:0] w_sum;
  logic                  w_alu_cout;
  logic                  w_alu_ovf;
  logic                  w_word_zero;
  logic [W+WORD_WIDTH-1:0] w_res_cat;
  logic [W-1:0]          w_res_shift;

  // Narrow ALU: subtract is A + ~B + carry, with the carry register seeded to 1.
  assign w_add_mode  = ~r_mode;
  assign w_op_a      = r_a[WORD_WIDTH-1:0];
  assign w_op_b      = w_add_mode ? r_b[WORD_WIDTH-1:0] : ~r_b[WORD_WIDTH-1:0];
  assign w_sum_ext   = {1'b0, w_op_a} + {1'b0, w_op_b} + {{WORD_WIDTH{1'b0}}, r_carry};
  assign w_sum       = w_sum_ext[WORD_WIDTH-1:0];
  assign w_alu_cout  = w_sum_ext[WORD_WIDTH];
  assign w_alu_ovf   = (w_op_a[WORD_WIDTH-1] == w_op_b[WORD_WIDTH-1]) &&
                       (w_sum[WORD_WIDTH-1] != w_op_a[WORD_WIDTH-1]);
  assign w_word_zero = (w_sum == '0);

  // New word enters at the top; after NUM_WORDS passes word 0 sits at the bottom.
  assign w_res_cat   = {w_sum, r_res_sh};
  assign w_res_shift = w_res_cat[W+WORD_WIDTH-1:WORD_WIDTH];

  assign w_last = (r_cnt == CNT_W'(NUM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:                 w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_DONE:  w_done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_res_sh    <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_mode      <= 1'b0;
      r_zero_acc  <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a        <= bus.operandA;
            r_b        <= bus.operandB;
            r_cnt      <= '0;
            r_carry    <= bus.carryInEnable ? bus.carryIn : bus.subtract;
            r_mode     <= bus.subtract;
            r_zero_acc <= 1'b1;
          end
        end
        S_RUN: begin
          r_res_sh   <= w_res_shift;
          r_a        <= r_a >> WORD_WIDTH;
          r_b        <= r_b >> WORD_WIDTH;
          r_carry    <= w_alu_cout;
          r_zero_acc <= r_zero_acc & w_word_zero;
          r_cnt      <= r_cnt + 1'b1;
          if (w_last) begin
            r_result    <= w_res_shift;
            r_carry_out <= w_alu_cout;
            r_ovf       <= w_alu_ovf;
            r_zero      <= r_zero_acc & w_word_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = w_ready;
  assign bus.done        = w_done;
  assign bus.result      = r_result;
  assign bus.carryOut    = r_carry_out;
  assign bus.overflowOut = r_ovf;
  assign bus.zeroOut     = r_zero;
endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer with default parameters (4 x 8-bit words).
`timescale 1ns/1ps
module tb_alu_word_sequencer;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  alu_word_sequencer_if #(.WORD_WIDTH(8), .NUM_WORDS(4)) bus ();

  alu_word_sequencer #(.WORD_WIDTH(8), .NUM_WORDS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation and counts negedges until done (99 on timeout).
  task automatic do_op(input logic sub, input logic cie, input logic cin,
                       input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic rdy_after);
    @(negedge clk);
    bus.subtract      = sub;
    bus.carryInEnable = cie;
    bus.carryIn       = cin;
    bus.operandA      = a;
    bus.operandB      = b;
    bus.start         = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    rdy_after = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) rdy_after = bus.ready;
      if (bus.done) break;
    end
    if (!bus.done) lat = 99;
  endtask

  task automatic test_reset();
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.subtract      = 1'b0;
    bus.carryInEnable = 1'b0;
    bus.carryIn       = 1'b0;
    bus.operandA      = '0;
    bus.operandB      = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hs: ready=%b done=%b expected ready=1 done=0", bus.ready, bus.done);
    end
    n_checks++;
    if (bus.result !== 32'h0 || bus.carryOut !== 1'b0 || bus.overflowOut !== 1'b0 || bus.zeroOut !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_out: result=%h c=%b v=%b z=%b expected all 0",
               bus.result, bus.carryOut, bus.overflowOut, bus.zeroOut);
    end
    reset = 1'b0;
    $display("reset: ready=%b result=%h", bus.ready, bus.result);
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [31:0] ta [9] = '{32'h000000FF, 32'h12345678, 32'h00000000, 32'h7FFFFFFF,
                            32'hFFFFFFFF, 32'h00000000, 32'h00000005, 32'h80000000,
                            32'h0000FF00};
    logic [31:0] tb [9] = '{32'h00000001, 32'h12345678, 32'h00000001, 32'h00000001,
                            32'h00000001, 32'h00000000, 32'h00000003, 32'h00000001,
                            32'h00000100};
    logic        tsub [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        tcie [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        tcin [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] tres [9] = '{32'h00000100, 32'h00000000, 32'hFFFFFFFF, 32'h80000000,
                              32'h00000000, 32'h00000001, 32'h00000001, 32'h7FFFFFFF,
                              32'h00010000};
    logic        tc [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        tv [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        tz [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int          lat;
    logic        rdy;
    for (int i = 0; i < 9; i++) begin
      do_op(tsub[i], tcie[i], tcin[i], ta[i], tb[i], lat, rdy);
      $display("op %0d: sub=%b cie=%b cin=%b a=%h b=%h -> result=%h c=%b v=%b z=%b lat=%0d",
               i, tsub[i], tcie[i], tcin[i], ta[i], tb[i], bus.result,
               bus.carryOut, bus.overflowOut, bus.zeroOut, lat);
      n_checks++;
      if (lat !== 5 || rdy !== 1'b0) begin
        n_errors++;
        $display("FAIL arith_latency[%0d]: lat=%0d ready_after=%b expected lat=5 ready_after=0", i, lat, rdy);
      end
      n_checks++;
      if (bus.result !== tres[i]) begin
        n_errors++;
        $display("FAIL arith_result[%0d]: got %h expected %h", i, bus.result, tres[i]);
      end
      n_checks++;
      if (bus.carryOut !== tc[i] || bus.overflowOut !== tv[i] || bus.zeroOut !== tz[i]) begin
        n_errors++;
        $display("FAIL arith_flags[%0d]: c=%b v=%b z=%b expected c=%b v=%b z=%b",
                 i, bus.carryOut, bus.overflowOut, bus.zeroOut, tc[i], tv[i], tz[i]);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.result !== tres[i]) begin
        n_errors++;
        $display("FAIL arith_after_done[%0d]: done=%b ready=%b result=%h expected done=0 ready=1 result=%h",
                 i, bus.done, bus.ready, bus.result, tres[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    bus.subtract      = 1'b0;
    bus.carryInEnable = 1'b0;
    bus.carryIn       = 1'b0;
    bus.operandA      = 32'h11111111;
    bus.operandB      = 32'h22222222;
    bus.start         = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      #1;
      bus.subtract      = 1'b1;
      bus.carryInEnable = 1'b1;
      bus.carryIn       = 1'b1;
      bus.operandA      = 32'hFFFFFFFF - i;
      bus.operandB      = 32'h01010101 * i;
      bus.start         = 1'b1;
      n_checks++;
      if (bus.ready !== 1'b0) begin
        n_errors++;
        $display("FAIL ignore_ready[%0d]: ready=%b expected 0", i, bus.ready);
      end
      @(posedge clk);
    end
    #1 bus.start = 1'b0;
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i + 1;
        break;
      end
    end
    $display("ignore_start: result=%h c=%b lat=%0d", bus.result, bus.carryOut, lat);
    n_checks++;
    if (lat !== 2) begin
      n_errors++;
      $display("FAIL ignore_latency: got %0d expected 2", lat);
    end
    n_checks++;
    if (bus.result !== 32'h33333333 || bus.carryOut !== 1'b0 || bus.zeroOut !== 1'b0) begin
      n_errors++;
      $display("FAIL ignore_result: result=%h c=%b z=%b expected 33333333 c=0 z=0",
               bus.result, bus.carryOut, bus.zeroOut);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int pulses;
    int first_idx;
    int second_idx;
    pulses     = 0;
    first_idx  = -1;
    second_idx = -1;
    @(negedge clk);
    bus.subtract      = 1'b0;
    bus.carryInEnable = 1'b0;
    bus.carryIn       = 1'b0;
    bus.operandA      = 32'h00010000;
    bus.operandB      = 32'h0000FFFF;
    bus.start         = 1'b1;
    for (int idx = 1; idx <= 18; idx++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (first_idx < 0) first_idx = idx;
        else if (second_idx < 0) second_idx = idx;
        $display("back_to_back: done at cycle %0d result=%h", idx, bus.result);
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (pulses !== 3 || first_idx !== 5) begin
      n_errors++;
      $display("FAIL b2b_pulses: pulses=%0d first=%0d expected pulses=3 first=5", pulses, first_idx);
    end
    n_checks++;
    if (second_idx - first_idx !== 6) begin
      n_errors++;
      $display("FAIL b2b_period: got %0d expected 6", second_idx - first_idx);
    end
    n_checks++;
    if (bus.result !== 32'h0001FFFF || bus.carryOut !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_result: result=%h c=%b expected 0001ffff c=0", bus.result, bus.carryOut);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int   pulses;
    int   lat;
    logic rdy;
    @(negedge clk);
    bus.subtract      = 1'b0;
    bus.carryInEnable = 1'b0;
    bus.carryIn       = 1'b0;
    bus.operandA      = 32'hFFFFFFFF;
    bus.operandB      = 32'h00000001;
    bus.start         = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("reset_mid_run: ready=%b done=%b result=%h", bus.ready, bus.done, bus.result);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_hs: ready=%b done=%b expected ready=1 done=0", bus.ready, bus.done);
    end
    n_checks++;
    if (bus.result !== 32'h0 || bus.carryOut !== 1'b0 || bus.overflowOut !== 1'b0 || bus.zeroOut !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_out: result=%h c=%b v=%b z=%b expected all 0",
               bus.result, bus.carryOut, bus.overflowOut, bus.zeroOut);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_errors++;
      $display("FAIL midrst_no_done: pulses=%0d expected 0", pulses);
    end
    do_op(1'b0, 1'b0, 1'b0, 32'h00000002, 32'h00000003, lat, rdy);
    $display("after_reset op: result=%h c=%b lat=%0d", bus.result, bus.carryOut, lat);
    n_checks++;
    if (lat !== 5 || bus.result !== 32'h00000005 || bus.carryOut !== 1'b0 || bus.zeroOut !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_new_op: lat=%0d result=%h c=%b z=%b expected lat=5 00000005 c=0 z=0",
               lat, bus.result, bus.carryOut, bus.zeroOut);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_arith();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
